// File: rtl/commit_pkg.sv
// Shared types for the wide commit stage: ROB entry layout, command and
// condition encodings, FSM states and the condition evaluator.
package commit_pkg;

  localparam int unsigned ENTRY_W = 79;

  typedef enum logic [3:0] {
    CMD_ALU      = 4'd0,
    CMD_STORE    = 4'd1,
    CMD_BCOND_NT = 4'd2,
    CMD_BCOND_T  = 4'd3,
    CMD_CBZ_NT   = 4'd4,
    CMD_CBZ_T    = 4'd5,
    CMD_BR       = 4'd6,
    CMD_BL       = 4'd7,
    CMD_B        = 4'd8,
    CMD_LOAD     = 4'd9
  } cmd_e;

  localparam logic [4:0] COND_EQ = 5'd0;
  localparam logic [4:0] COND_NE = 5'd1;
  localparam logic [4:0] COND_GE = 5'd10;
  localparam logic [4:0] COND_LT = 5'd11;
  localparam logic [4:0] COND_GT = 5'd12;

  typedef enum logic {
    ST_COMMIT  = 1'b0,
    ST_RESTORE = 1'b1
  } state_e;

  // flags are {C,V,Z,N}
  typedef struct packed {
    logic [3:0]  cmd;
    logic [4:0]  rd;
    logic        flag_valid;
    logic [3:0]  flags;
    logic        data_valid;
    logic [63:0] data;
  } rob_entry_t;

  function automatic logic cond_taken(input logic [4:0] cond, input logic v,
                                      input logic z, input logic n);
    logic t;
    case (cond)
      COND_EQ: t = z;
      COND_NE: t = !z;
      COND_GE: t = (n == v);
      COND_LT: t = (n != v);
      COND_GT: t = !z && (n == v);
      default: t = z || (n != v);
    endcase
    return t;
  endfunction

endpackage

// File: rtl/commit_lane_eval.sv
// Per-lane decode of one ROB entry: branch resolution, write enable and
// flag forwarding toward the next lane.
module commit_lane_eval
  import commit_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  rob_entry_t      i_entry,
  input  logic [XLEN-1:0] i_reg_data,
  input  logic [3:0]      i_flags,
  output logic            o_retire_ok_c,
  output logic            o_mispredict_c,
  output logic [XLEN-1:0] o_restore_pc_c,
  output logic            o_reg_we_c,
  output logic            o_is_store_c,
  output logic            o_is_load_c,
  output logic            o_is_cond_c,
  output logic            o_taken_c,
  output logic [3:0]      o_flags_out_c
);

  logic [XLEN-1:0] w_data;
  logic            w_cond_hit;
  logic            w_reg_zero;

  assign w_data        = XLEN'(i_entry.data);
  assign w_cond_hit    = cond_taken(i_entry.rd, i_flags[2], i_flags[1], i_flags[0]);
  assign w_reg_zero    = (i_reg_data == '0);
  assign o_retire_ok_c = i_entry.data_valid;
  assign o_flags_out_c = i_entry.flag_valid ? i_entry.flags : i_flags;

  always_comb begin
    o_mispredict_c = 1'b0;
    o_restore_pc_c = w_data;
    o_reg_we_c     = 1'b0;
    o_is_store_c   = 1'b0;
    o_is_load_c    = 1'b0;
    o_is_cond_c    = 1'b0;
    o_taken_c      = 1'b0;
    case (i_entry.cmd)
      CMD_ALU, CMD_BL: o_reg_we_c = 1'b1;
      CMD_LOAD: begin
        o_reg_we_c  = 1'b1;
        o_is_load_c = 1'b1;
      end
      CMD_STORE: o_is_store_c = 1'b1;
      CMD_BCOND_NT, CMD_BCOND_T: begin
        o_is_cond_c    = 1'b1;
        o_taken_c      = w_cond_hit;
        o_mispredict_c = (w_cond_hit != i_entry.cmd[0]);
      end
      CMD_CBZ_NT, CMD_CBZ_T: begin
        o_is_cond_c    = 1'b1;
        o_taken_c      = w_reg_zero;
        o_mispredict_c = (w_reg_zero != i_entry.cmd[0]);
      end
      // indirect branch: prediction lives in data, real target in the regfile
      CMD_BR: begin
        o_mispredict_c = (i_reg_data != w_data);
        o_restore_pc_c = i_reg_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/commit_stage_wide.sv
// Multi-lane in-order commit stage with mispredict squash and registered
// restore handshake. Optional perf counters under `COMMIT_PERF_CNT_EN.
module commit_stage_wide
  import commit_pkg::*;
#(
  parameter int unsigned ROB_SIZE  = 8,
  parameter int unsigned ROB_PTR_W = $clog2(ROB_SIZE + 1),
  parameter int unsigned COMMIT_W  = 2,
  parameter int unsigned XLEN      = 64
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [ROB_PTR_W-1:0]            rob_head_i,
  input  logic [COMMIT_W*ENTRY_W-1:0]     rob_entry_i,
  output logic [$clog2(COMMIT_W+1)-1:0]   rob_retire_cnt_o,
  output logic [COMMIT_W*5-1:0]           map_rd_addr_o,
  input  logic [COMMIT_W*ROB_PTR_W-1:0]   map_rd_data_i,
  output logic [31:0]                     map_resets_o,
  output logic [COMMIT_W*5-1:0]           reg_rd_addr_o,
  input  logic [COMMIT_W*XLEN-1:0]        reg_rd_data_i,
  output logic [COMMIT_W-1:0]             reg_we_o,
  output logic [COMMIT_W*5-1:0]           reg_waddr_o,
  output logic [COMMIT_W*XLEN-1:0]        reg_wdata_o,
  output logic                            mem_wr_valid_o,
  input  logic                            mem_wr_ready_i,
  output logic [XLEN-1:0]                 mem_wr_addr_o,
  output logic [XLEN-1:0]                 mem_wr_data_o,
  output logic [COMMIT_W-1:0]             lsq_retire_o,
  input  logic                            lsq_flush_i,
  input  logic [XLEN-1:0]                 lsq_pc_i,
  output logic                            restore_valid_o,
  output logic [XLEN-1:0]                 restore_pc_o,
  input  logic                            restore_ack_i,
  output logic                            bp_update_o,
  output logic                            bp_taken_o
`ifdef COMMIT_PERF_CNT_EN
  ,
  output logic [31:0]                     perf_retired_o,
  output logic [31:0]                     perf_mispred_o,
  output logic [31:0]                     perf_stall_o
`endif
);

  localparam int unsigned CNT_W = $clog2(COMMIT_W + 1);

  rob_entry_t            w_entry     [COMMIT_W];
  logic [3:0]            w_flags_in  [COMMIT_W];
  logic [3:0]            w_flags_out [COMMIT_W];
  logic [XLEN-1:0]       w_lane_pc   [COMMIT_W];
  logic [XLEN-1:0]       w_lane_rd   [COMMIT_W];
  logic [COMMIT_W-1:0]   w_ok, w_misp, w_we, w_store, w_load, w_cond, w_taken;

  state_e                r_state;
  logic [3:0]            r_flags;
  logic                  r_restore_valid;
  logic [XLEN-1:0]       r_restore_pc;

  logic                  w_go, w_store_seen, w_cond_seen, w_mispred, w_lane_misp;
  logic [XLEN-1:0]       w_rpc;
  logic [3:0]            w_flags_nxt;
  logic [ROB_PTR_W-1:0]  w_slot;

  for (genvar k = 0; k < COMMIT_W; k++) begin : g_lane
    assign w_entry[k]   = rob_entry_t'(rob_entry_i[k*ENTRY_W +: ENTRY_W]);
    assign w_lane_rd[k] = reg_rd_data_i[k*XLEN +: XLEN];
    if (k == 0) begin : g_first
      assign w_flags_in[k] = r_flags;
    end else begin : g_chain
      assign w_flags_in[k] = w_flags_out[k-1];
    end

    commit_lane_eval #(.XLEN(XLEN)) u_lane (
      .i_entry        (w_entry[k]),
      .i_reg_data     (w_lane_rd[k]),
      .i_flags        (w_flags_in[k]),
      .o_retire_ok_c  (w_ok[k]),
      .o_mispredict_c (w_misp[k]),
      .o_restore_pc_c (w_lane_pc[k]),
      .o_reg_we_c     (w_we[k]),
      .o_is_store_c   (w_store[k]),
      .o_is_load_c    (w_load[k]),
      .o_is_cond_c    (w_cond[k]),
      .o_taken_c      (w_taken[k]),
      .o_flags_out_c  (w_flags_out[k])
    );

    assign map_rd_addr_o[k*5 +: 5]     = w_entry[k].rd;
    assign reg_rd_addr_o[k*5 +: 5]     = w_entry[k].rd;
    assign reg_waddr_o[k*5 +: 5]       = w_entry[k].rd;
    assign reg_wdata_o[k*XLEN +: XLEN] = XLEN'(w_entry[k].data);
  end

  // Walk lanes in order; the retired set is the prefix before the first stop.
  always_comb begin
    rob_retire_cnt_o = '0;
    map_resets_o     = '0;
    reg_we_o         = '0;
    lsq_retire_o     = '0;
    mem_wr_valid_o   = 1'b0;
    mem_wr_addr_o    = '0;
    mem_wr_data_o    = '0;
    bp_update_o      = 1'b0;
    bp_taken_o       = 1'b0;
    w_mispred        = 1'b0;
    w_lane_misp      = 1'b0;
    w_rpc            = '0;
    w_flags_nxt      = r_flags;
    w_store_seen     = 1'b0;
    w_cond_seen      = 1'b0;
    w_slot           = '0;
    w_go             = reset_i && (r_state == ST_COMMIT);
    for (int k = 0; k < COMMIT_W; k++) begin
      if (w_go) begin
        if (!w_ok[k] || (w_store[k] && w_store_seen) || (w_cond[k] && w_cond_seen)) begin
          w_go = 1'b0;
        end else if (w_store[k] && !mem_wr_ready_i) begin
          mem_wr_valid_o = 1'b1;
          mem_wr_addr_o  = XLEN'(w_entry[k].data);
          mem_wr_data_o  = w_lane_rd[k];
          w_go           = 1'b0;
        end else begin
          rob_retire_cnt_o = CNT_W'(rob_retire_cnt_o + 1'b1);
          w_flags_nxt      = w_flags_out[k];
          w_slot = ROB_PTR_W'((32'(rob_head_i) + 32'(k)) % ROB_SIZE);
          if (w_we[k]) begin
            reg_we_o[k] = 1'b1;
            if (map_rd_data_i[k*ROB_PTR_W +: ROB_PTR_W] == w_slot)
              map_resets_o[w_entry[k].rd] = 1'b1;
          end
          if (w_store[k]) begin
            w_store_seen    = 1'b1;
            mem_wr_valid_o  = 1'b1;
            mem_wr_addr_o   = XLEN'(w_entry[k].data);
            mem_wr_data_o   = w_lane_rd[k];
            lsq_retire_o[k] = 1'b1;
          end
          if (w_load[k]) lsq_retire_o[k] = 1'b1;
          if (w_cond[k]) begin
            w_cond_seen = 1'b1;
            bp_update_o = 1'b1;
            bp_taken_o  = w_taken[k];
          end
          w_lane_misp = w_misp[k] || (w_store[k] && lsq_flush_i);
          if (w_lane_misp) begin
            w_mispred = 1'b1;
            w_rpc     = (w_store[k] && lsq_flush_i) ? lsq_pc_i : w_lane_pc[k];
            w_go      = 1'b0;
          end
        end
      end
    end
  end

  // Commit/restore FSM with registered restore request and flag register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state         <= ST_COMMIT;
      r_flags         <= '0;
      r_restore_valid <= 1'b0;
      r_restore_pc    <= '0;
    end else begin
      case (r_state)
        ST_COMMIT: begin
          r_flags <= w_flags_nxt;
          if (w_mispred) begin
            r_state         <= ST_RESTORE;
            r_restore_valid <= 1'b1;
            r_restore_pc    <= w_rpc;
          end
        end
        ST_RESTORE: begin
          if (restore_ack_i) begin
            r_state         <= ST_COMMIT;
            r_restore_valid <= 1'b0;
          end
        end
        default: r_state <= ST_COMMIT;
      endcase
    end
  end

  assign restore_valid_o = r_restore_valid;
  assign restore_pc_o    = r_restore_pc;

`ifdef COMMIT_PERF_CNT_EN
  logic [31:0] r_perf_retired, r_perf_mispred, r_perf_stall;
  logic [32:0] w_ret_sum;

  assign w_ret_sum = {1'b0, r_perf_retired} + 33'(rob_retire_cnt_o);

  // Saturating event counters.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_perf_retired <= '0;
      r_perf_mispred <= '0;
      r_perf_stall   <= '0;
    end else begin
      r_perf_retired <= w_ret_sum[32] ? '1 : w_ret_sum[31:0];
      if (w_mispred && (r_perf_mispred != '1))
        r_perf_mispred <= r_perf_mispred + 32'd1;
      if (w_entry[0].data_valid && (rob_retire_cnt_o == '0) && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_retired_o = r_perf_retired;
  assign perf_mispred_o = r_perf_mispred;
  assign perf_stall_o   = r_perf_stall;
`endif

endmodule

// File: tb/tb_commit_stage_wide.sv
// Self-checking bench for commit_stage_wide: vector table plus hand-written
// restore, store-stall, reset and double-store sequences.
module tb_commit_stage_wide;
  import commit_pkg::*;

  localparam int unsigned XLEN = 64;
  localparam int unsigned CW   = 2;
  localparam int unsigned PW   = 4;

  typedef struct {
    logic [1:0]  cnt;
    logic [1:0]  we;
    logic [31:0] map;
    logic [1:0]  lsq;
    logic        mv;
    logic [63:0] ma;
    logic [63:0] md;
    logic        bu;
    logic        bt;
    logic        rv;
    logic [63:0] rpc;
  } exp_t;

  typedef struct {
    rob_entry_t  e0;
    rob_entry_t  e1;
    logic [3:0]  head;
    logic [3:0]  t0;
    logic [3:0]  t1;
    logic [63:0] r0;
    logic [63:0] r1;
    logic        rdy;
    exp_t        x;
  } vec_t;

  logic                  clk_i = 1'b0;
  logic                  reset_i;
  logic [PW-1:0]         rob_head_i;
  logic [CW*ENTRY_W-1:0] rob_entry_i;
  logic [1:0]            rob_retire_cnt_o;
  logic [CW*5-1:0]       map_rd_addr_o;
  logic [CW*PW-1:0]      map_rd_data_i;
  logic [31:0]           map_resets_o;
  logic [CW*5-1:0]       reg_rd_addr_o;
  logic [CW*XLEN-1:0]    reg_rd_data_i;
  logic [CW-1:0]         reg_we_o;
  logic [CW*5-1:0]       reg_waddr_o;
  logic [CW*XLEN-1:0]    reg_wdata_o;
  logic                  mem_wr_valid_o;
  logic                  mem_wr_ready_i;
  logic [XLEN-1:0]       mem_wr_addr_o;
  logic [XLEN-1:0]       mem_wr_data_o;
  logic [CW-1:0]         lsq_retire_o;
  logic                  lsq_flush_i;
  logic [XLEN-1:0]       lsq_pc_i;
  logic                  restore_valid_o;
  logic [XLEN-1:0]       restore_pc_o;
  logic                  restore_ack_i;
  logic                  bp_update_o;
  logic                  bp_taken_o;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  vec_t vt[12];

  commit_stage_wide #(.ROB_SIZE(8), .COMMIT_W(CW), .XLEN(XLEN)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .rob_head_i(rob_head_i), .rob_entry_i(rob_entry_i),
    .rob_retire_cnt_o(rob_retire_cnt_o), .map_rd_addr_o(map_rd_addr_o),
    .map_rd_data_i(map_rd_data_i), .map_resets_o(map_resets_o),
    .reg_rd_addr_o(reg_rd_addr_o), .reg_rd_data_i(reg_rd_data_i), .reg_we_o(reg_we_o),
    .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o), .mem_wr_valid_o(mem_wr_valid_o),
    .mem_wr_ready_i(mem_wr_ready_i), .mem_wr_addr_o(mem_wr_addr_o),
    .mem_wr_data_o(mem_wr_data_o), .lsq_retire_o(lsq_retire_o), .lsq_flush_i(lsq_flush_i),
    .lsq_pc_i(lsq_pc_i), .restore_valid_o(restore_valid_o), .restore_pc_o(restore_pc_o),
    .restore_ack_i(restore_ack_i), .bp_update_o(bp_update_o), .bp_taken_o(bp_taken_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic rob_entry_t mke(input int cmd, input int rd, input int fv,
                                     input int fl, input int dv, input logic [63:0] data);
    rob_entry_t e;
    e.cmd = 4'(cmd); e.rd = 5'(rd); e.flag_valid = 1'(fv);
    e.flags = 4'(fl); e.data_valid = 1'(dv); e.data = data;
    return e;
  endfunction

  function automatic exp_t mkx(input int cnt, input int we, input logic [31:0] map,
                               input int lsq, input int bu, input int bt);
    exp_t x;
    x.cnt = 2'(cnt); x.we = 2'(we); x.map = map; x.lsq = 2'(lsq);
    x.mv = 1'b0; x.ma = '0; x.md = '0; x.bu = 1'(bu); x.bt = 1'(bt);
    x.rv = 1'b0; x.rpc = '0;
    return x;
  endfunction

  function automatic exp_t mkm(input exp_t xi, input logic [63:0] a, input logic [63:0] d);
    exp_t x = xi;
    x.mv = 1'b1; x.ma = a; x.md = d;
    return x;
  endfunction

  function automatic exp_t mkr(input exp_t xi, input logic [63:0] pc);
    exp_t x = xi;
    x.rv = 1'b1; x.rpc = pc;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t x;
    if (q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard_empty", tag);
      return;
    end
    x = q.pop_front();
    chk({tag, ".cnt"}, 64'(rob_retire_cnt_o), 64'(x.cnt));
    chk({tag, ".we"},  64'(reg_we_o),         64'(x.we));
    chk({tag, ".map"}, 64'(map_resets_o),     64'(x.map));
    chk({tag, ".lsq"}, 64'(lsq_retire_o),     64'(x.lsq));
    chk({tag, ".mv"},  64'(mem_wr_valid_o),   64'(x.mv));
    chk({tag, ".bu"},  64'(bp_update_o),      64'(x.bu));
    chk({tag, ".rv"},  64'(restore_valid_o),  64'(x.rv));
    if (x.mv) begin
      chk({tag, ".ma"}, mem_wr_addr_o, x.ma);
      chk({tag, ".md"}, mem_wr_data_o, x.md);
    end
    if (x.bu) chk({tag, ".bt"}, 64'(bp_taken_o), 64'(x.bt));
    if (x.rv) chk({tag, ".rpc"}, restore_pc_o, x.rpc);
  endtask

  task automatic drive(input rob_entry_t e0, input rob_entry_t e1, input logic [3:0] head,
                       input logic [3:0] t0, input logic [3:0] t1, input logic [63:0] r0,
                       input logic [63:0] r1, input logic rdy);
    rob_entry_i    = {e1, e0};
    rob_head_i     = head;
    map_rd_data_i  = {t1, t0};
    reg_rd_data_i  = {r1, r0};
    mem_wr_ready_i = rdy;
  endtask

  task automatic step(input string tag, input rob_entry_t e0, input rob_entry_t e1,
                      input logic [3:0] head, input logic [3:0] t0, input logic [3:0] t1,
                      input logic [63:0] r0, input logic [63:0] r1, input logic rdy,
                      input logic flush, input logic ack, input exp_t x);
    @(posedge clk_i);
    #1;
    drive(e0, e1, head, t0, t1, r0, r1, rdy);
    lsq_flush_i   = flush;
    restore_ack_i = ack;
    q.push_back(x);
    @(negedge clk_i);
    check_out(tag);
    if (x.we[0]) begin
      chk({tag, ".wa0"}, 64'(reg_waddr_o[4:0]), 64'(e0.rd));
      chk({tag, ".wd0"}, reg_wdata_o[63:0], e0.data);
    end
    if (x.we[1]) begin
      chk({tag, ".wa1"}, 64'(reg_waddr_o[9:5]), 64'(e1.rd));
      chk({tag, ".wd1"}, reg_wdata_o[127:64], e1.data);
    end
  endtask

  initial begin
    rob_entry_t a, b, inv;
    exp_t zero;
    a    = mke(0, 10, 0, 0, 1, 64'h1);
    b    = mke(0, 11, 0, 0, 1, 64'h2);
    inv  = mke(15, 0, 0, 0, 0, 64'h0);
    zero = mkx(0, 0, 32'h0, 0, 0, 0);

    vt[0]  = '{mke(0,3,0,0,1,64'h11), mke(0,5,0,0,1,64'h22), 4'd0, 4'd0, 4'd1, 64'h0, 64'h0, 1'b1,
               mkx(2, 3, 32'h28, 0, 0, 0)};
    vt[1]  = '{mke(0,3,0,0,0,64'h11), mke(0,5,0,0,1,64'h22), 4'd0, 4'd0, 4'd1, 64'h0, 64'h0, 1'b1,
               mkx(0, 0, 32'h0, 0, 0, 0)};
    vt[2]  = '{mke(0,2,0,0,1,64'h33), mke(0,9,0,0,0,64'h44), 4'd7, 4'd7, 4'd0, 64'h0, 64'h0, 1'b1,
               mkx(1, 1, 32'h4, 0, 0, 0)};
    vt[3]  = '{mke(0,1,0,0,1,64'h55), mke(0,4,0,0,1,64'h66), 4'd7, 4'd3, 4'd0, 64'h0, 64'h0, 1'b1,
               mkx(2, 3, 32'h10, 0, 0, 0)};
    vt[4]  = '{mke(9,6,0,0,1,64'h77), mke(15,7,0,0,1,64'h0), 4'd2, 4'd2, 4'd3, 64'h0, 64'h0, 1'b1,
               mkx(2, 1, 32'h40, 1, 0, 0)};
    vt[5]  = '{mke(0,0,1,2,1,64'h88), mke(3,0,0,0,1,64'h500), 4'd4, 4'd5, 4'd0, 64'h0, 64'h0, 1'b1,
               mkx(2, 1, 32'h0, 0, 1, 1)};
    vt[6]  = '{mke(2,1,0,0,1,64'h600), mke(2,0,0,0,1,64'h700), 4'd0, 4'd0, 4'd0, 64'h0, 64'h0, 1'b1,
               mkx(1, 0, 32'h0, 0, 1, 0)};
    vt[7]  = '{mke(4,2,0,0,1,64'h900), mke(6,3,0,0,1,64'h1234), 4'd0, 4'd7, 4'd7, 64'h5, 64'h1234, 1'b1,
               mkx(2, 0, 32'h0, 0, 1, 0)};
    vt[8]  = '{mke(8,0,0,0,1,64'hA00), mke(7,30,0,0,1,64'hB00), 4'd0, 4'd0, 4'd1, 64'h0, 64'h0, 1'b1,
               mkx(2, 2, 32'h4000_0000, 0, 0, 0)};
    vt[9]  = '{mke(1,4,0,0,1,64'h100), mke(0,5,0,0,1,64'hC00), 4'd0, 4'd0, 4'd7, 64'hDEAD, 64'h0, 1'b1,
               mkm(mkx(2, 2, 32'h0, 1, 0, 0), 64'h100, 64'hDEAD)};
    vt[10] = '{mke(0,2,0,0,1,64'hD00), mke(1,6,0,0,1,64'h200), 4'd0, 4'd5, 4'd0, 64'h0, 64'hBEEF, 1'b0,
               mkm(mkx(1, 1, 32'h0, 0, 0, 0), 64'h200, 64'hBEEF)};
    vt[11] = '{mke(0,3,1,1,1,64'hE00), mke(3,11,0,0,1,64'hF00), 4'd0, 4'd5, 4'd0, 64'h0, 64'h0, 1'b1,
               mkx(2, 1, 32'h0, 0, 1, 1)};

    // reset state with valid entries presented
    reset_i = 1'b0; lsq_flush_i = 1'b0; restore_ack_i = 1'b0; lsq_pc_i = 64'h777;
    drive(a, b, 4'd0, 4'd7, 4'd7, 64'h0, 64'h0, 1'b1);
    q.push_back(zero);
    @(negedge clk_i);
    check_out("rst");
    chk("rst.rpc", restore_pc_o, 64'h0);
    @(posedge clk_i); #1 reset_i = 1'b1;

    for (int i = 0; i < 12; i++)
      step($sformatf("vec%0d", i), vt[i].e0, vt[i].e1, vt[i].head, vt[i].t0, vt[i].t1,
           vt[i].r0, vt[i].r1, vt[i].rdy, 1'b0, 1'b0, vt[i].x);

    // B.EQ mispredict in lane 1 using lane-0 flags, restore held until ack
    step("beq", mke(0,1,1,2,1,64'h10), mke(2,0,0,0,1,64'h4000), 4'd0, 4'd7, 4'd7,
         64'h0, 64'h0, 1'b1, 1'b0, 1'b0, mkx(2, 1, 32'h0, 0, 1, 1));
    step("beq_r1", a, b, 4'd0, 4'd7, 4'd7, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, mkr(zero, 64'h4000));
    step("beq_r2", a, b, 4'd0, 4'd7, 4'd7, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, mkr(zero, 64'h4000));
    step("beq_ack", a, b, 4'd0, 4'd7, 4'd7, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1, mkr(zero, 64'h4000));
    step("beq_post", a, b, 4'd0, 4'd7, 4'd7, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, mkx(2, 3, 32'h0, 0, 0, 0));

    // store waits on memory ready
    for (int i = 0; i < 3; i++)
      step($sformatf("stall%0d", i), mke(1,0,0,0,1,64'h300), mke(0,12,0,0,1,64'h5), 4'd0, 4'd7, 4'd7,
           64'hAA, 64'h0, 1'b0, 1'b0, 1'b0, mkm(zero, 64'h300, 64'hAA));
    step("stall_go", mke(1,0,0,0,1,64'h300), mke(0,12,0,0,1,64'h5), 4'd0, 4'd7, 4'd7,
         64'hAA, 64'h0, 1'b1, 1'b0, 1'b0, mkm(mkx(2, 2, 32'h0, 1, 0, 0), 64'h300, 64'hAA));

    // CBZ predicted taken with nonzero register
    step("cbz", mke(5,0,0,0,1,64'h5000), mke(0,13,0,0,1,64'h6), 4'd0, 4'd7, 4'd7,
         64'h7, 64'h0, 1'b1, 1'b0, 1'b0, mkx(1, 0, 32'h0, 0, 1, 0));
    step("cbz_r", a, b, 4'd0, 4'd7, 4'd7, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1, mkr(zero, 64'h5000));
    step("cbz_post", a, b, 4'd0, 4'd7, 4'd7, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, mkx(2, 3, 32'h0, 0, 0, 0));

    // BR mispredict, then reset while in RESTORE
    step("br", mke(6,0,0,0,1,64'h99), b, 4'd0, 4'd7, 4'd7, 64'h88, 64'h0, 1'b1, 1'b0, 1'b0,
         mkx(1, 0, 32'h0, 0, 0, 0));
    step("br_r", a, b, 4'd0, 4'd7, 4'd7, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, mkr(zero, 64'h88));
    @(posedge clk_i); #1;
    drive(a, b, 4'd0, 4'd7, 4'd7, 64'h0, 64'h0, 1'b1);
    #1 reset_i = 1'b0;
    q.push_back(zero);
    @(negedge clk_i);
    check_out("rst_rs");
    chk("rst_rs.rpc", restore_pc_o, 64'h0);
    @(posedge clk_i); #1 reset_i = 1'b1;
    step("rst_flags", mke(2,0,0,0,1,64'h6000), mke(0,14,0,0,1,64'h7), 4'd0, 4'd7, 4'd7,
         64'h0, 64'h0, 1'b1, 1'b0, 1'b0, mkx(2, 2, 32'h0, 0, 1, 0));

    // two stores: one per cycle
    step("st2a", mke(1,0,0,0,1,64'h700), mke(1,0,0,0,1,64'h708), 4'd0, 4'd7, 4'd7,
         64'h1, 64'h2, 1'b1, 1'b0, 1'b0, mkm(mkx(1, 0, 32'h0, 1, 0, 0), 64'h700, 64'h1));
    step("st2b", mke(1,0,0,0,1,64'h708), inv, 4'd1, 4'd7, 4'd7,
         64'h2, 64'h0, 1'b1, 1'b0, 1'b0, mkm(mkx(1, 0, 32'h0, 1, 0, 0), 64'h708, 64'h2));

    // LSQ ordering violation on a store
    step("lsqf", mke(1,0,0,0,1,64'h800), a, 4'd0, 4'd7, 4'd7, 64'h3, 64'h0, 1'b1, 1'b1, 1'b0,
         mkm(mkx(1, 0, 32'h0, 1, 0, 0), 64'h800, 64'h3));
    step("lsqf_r", a, b, 4'd0, 4'd7, 4'd7, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1, mkr(zero, 64'h777));
    step("lsqf_post", a, b, 4'd0, 4'd7, 4'd7, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, mkx(2, 3, 32'h0, 0, 0, 0));

    chk("sb_drain", 64'(q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/commit_stage_wide.md
Name: commit_stage_wide

Overview:
- Parametrised successor of the single-entry commit stage.
- Retires up to COMMIT_W in-order ROB entries per cycle from the ROB head.
- Resolves B.cond, CBZ and BR mispredicts; stops and squashes at the first mispredict, then runs a registered restore handshake toward fetch.
- Sits between the ROB and the map table, regfile, data memory, LSQ and branch predictor.

Parameters:
- ROB_SIZE, 8: ROB depth, power of two.
- ROB_PTR_W, $clog2(ROB_SIZE+1): width of ROB head pointer and map-table tag.
- COMMIT_W, 2: commit lanes per cycle, 1..4.
- XLEN, 64: data and PC width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-low reset.
- rob_head_i  in  ROB_PTR_W  ROB index of lane 0.
- rob_entry_i  in  COMMIT_W*79  lane k = head+k; field layout is commit_pkg::rob_entry_t.
- rob_retire_cnt_o  out  $clog2(COMMIT_W+1)  entries retired this cycle; ROB advances head by this count.
- map_rd_addr_o  out  COMMIT_W*5  per-lane RD to map table.
- map_rd_data_i  in  COMMIT_W*ROB_PTR_W  per-lane map tag.
- map_resets_o  out  32  clear mask for map entries.
- reg_rd_addr_o  out  COMMIT_W*5  per-lane regfile read address.
- reg_rd_data_i  in  COMMIT_W*XLEN  per-lane regfile read data.
- reg_we_o  out  COMMIT_W  per-lane write enable.
- reg_waddr_o  out  COMMIT_W*5  per-lane write address.
- reg_wdata_o  out  COMMIT_W*XLEN  per-lane write data.
- mem_wr_valid_o  out  1  store request.
- mem_wr_ready_i  in  1  memory accepts the store.
- mem_wr_addr_o  out  XLEN  store address.
- mem_wr_data_o  out  XLEN  store data.
- lsq_retire_o  out  COMMIT_W  per-lane LSQ retire.
- lsq_flush_i  in  1  LSQ reports a store-order violation.
- lsq_pc_i  in  XLEN  restart PC for that violation.
- restore_valid_o  out  1  registered restore request.
- restore_pc_o  out  XLEN  registered restore PC.
- restore_ack_i  in  1  fetch and ROB flush complete.
- bp_update_o  out  1  predictor update strobe.
- bp_taken_o  out  1  resolved outcome.

Behaviour:
- Entry fields: cmd[78:75], rd[74:70], flag_valid[69], flags[68:65] ({C,V,Z,N}), data_valid[64], data[63:0].
- cmd encoding: 0 ALU, 1 STORE, 2/3 B.cond predicted not-taken/taken, 4/5 CBZ predicted not-taken/taken, 6 BR, 7 BL, 8 B, 9 LOAD, other NOP.
- Lane k retires iff:
  - all lanes below k retire;
  - data_valid is set;
  - FSM is COMMIT;
  - no earlier lane this cycle mispredicted or saw an LSQ flush.
  - Retired lanes form a contiguous prefix; rob_retire_cnt_o is the prefix length.
- Stores:
  - At most one store per cycle; a second store stops the prefix before it.
  - A store lane drives mem_wr_valid_o with addr = data and data = reg_rd_data_i; it retires only when mem_wr_ready_i is 1, otherwise the prefix stops there.
  - The store asserts lsq_retire_o; lsq_flush_i on that store is a mispredict with PC = lsq_pc_i.
- Flags: a 4-bit flag register updates on the youngest retiring lane with flag_valid set. A B.cond in lane k evaluates against the youngest retiring flag_valid lane below k, falling back to the register.
- Condition decode on rd: 0 EQ, 1 NE, 10 GE, 11 LT, 12 GT, others LE.
- Mispredict conditions:
  - B.cond: taken != cmd[0].
  - CBZ: (reg==0) != cmd[0].
  - BR: reg != data.
  - Restore PC is data for B.cond/CBZ and reg for BR.
- At most one mispredict is acted on per cycle, the lowest lane. That lane retires; all later lanes do not.
- bp_update_o/bp_taken_o come from the lowest retiring B.cond or CBZ lane; only one update per cycle, so a second conditional branch stops the prefix.
- Register writes: cmd 0/7/9 write when retiring. A lane also sets map_resets_o[rd] when map tag == (rob_head_i+k) mod ROB_SIZE. The regfile gives the higher lane priority on equal addresses.
- LOAD asserts lsq_retire_o.
- FSM:
  - COMMIT: on mispredict, register restore_pc and move to RESTORE.
  - RESTORE: restore_valid_o=1, retire count 0, all strobes 0; on restore_ack_i go to COMMIT the next cycle.
  - Restore latency is one cycle after the mispredict retires.
- Reset values: state COMMIT, flags 0, restore_valid_o 0, restore_pc_o 0. Every combinational strobe is 0 while reset_i is low; reset during RESTORE abandons the restore.

Optional Feature:
- COMMIT_PERF_CNT_EN: adds outputs perf_retired_o[31:0], perf_mispred_o[31:0] and perf_stall_o[31:0].
  - perf_retired_o adds the retire count each cycle.
  - perf_mispred_o counts restores.
  - perf_stall_o counts cycles with lane 0 data_valid but zero retired.
  - All counters reset to 0 and saturate.
- Without the macro, these ports and counters do not exist.

Decomposition:
- commit_pkg: rob_entry_t, cmd_e, cond codes, fsm state_e.
- One sub-module, commit_lane_eval, instantiated per lane: decodes the entry plus incoming flags into retire_ok, mispredict, restore_pc, reg_we, is_store and flags_out.

Test Plan:
- Two valid ALU entries, rd=3/5, tags match head/head+1 -> retire_cnt=2, reg_we=2'b11, map_resets_o=0x28.
- Lane0 CMP sets Z=1, lane1 B.EQ cmd=2 -> lane1 mispredicts; retire_cnt=2; next cycle restore_valid_o=1, restore_pc=lane1 data; held until restore_ack_i, then COMMIT.
- Lane0 STORE with mem_wr_ready_i=0 for 3 cycles -> retire_cnt=0 for 3 cycles; on ready=1, cnt=2 and lsq_retire_o[0]=1.
- Lane0 CBZ cmd=5 with reg=7, lane1 ALU -> cnt=1, lane1 squashed, restore_pc=data.
- reset_i low while in RESTORE -> restore_valid_o=0 immediately; after release, state is COMMIT with flags=0.
- Two stores in lanes 0 and 1, ready=1 -> cnt=1 this cycle, second store retires next cycle.
